ddr_sim_responder: RTL
======================

// Module: ddr_sim_responder
// PURPOSE
//  Behavioural DDR target for the sim_ram subsystem: the responder end of the DDR control interface driven by
//  the icache/dcache channel arbiter. Accepts one request at a time on ddr_chip_enable and models access latency
//  and PC burst-fill timing. Applies bit-masked 512-bit line writes and returns 512-bit line reads, then pulses
//  ddr_operation_done for one cycle.
// PARAMETERS
//  LINE_OFF        6    low index bits dropped to form line address (64-byte line)
//  DEPTH_LOG2      12   log2 of line count in storage array
//  READ_LATENCY    4    cycles from accept to done for single reads (>=1)
//  WRITE_LATENCY   2    cycles from accept to done for writes (>=1)
//  BURST_BEATS     8    extra cycles for burst reads (8 x 64-bit beats)
// PORTS
//  clock                 in   1    system clock, all logic on rising edge
//  reset                 in   1    synchronous, active-high reset
//  ddr_chip_enable       in   1    request valid; held high by initiator until done
//  ddr_index             in   64   byte address; line = index[LINE_OFF+DEPTH_LOG2-1:LINE_OFF]
//  ddr_write_enable      in   1    1 = write, 0 = read
//  ddr_burst_mode        in   1    1 = PC burst read (reads only)
//  ddr_write_mask        in   512  per-bit write enable
//  ddr_write_data        in   512  write line
//  ddr_read_data         out  512  read line, valid in done cycle, held afterwards
//  ddr_operation_done    out  1    one-cycle completion pulse (registered)
//  ddr_ready             out  1    high only in IDLE, when a new request can be accepted
//  ddr_protocol_error    out  1    sticky protocol-violation flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE, ddr_ready=1, ddr_operation_done=0, ddr_read_data=0, counter=0, error=0.
//   Storage is never reset: zero at time 0, contents preserved across reset.
//  FSM IDLE -> ACCESS -> [BURST] -> RESP -> IDLE.
//  IDLE: ready=1. On edge with ddr_chip_enable=1, latch index/we/burst/mask/data.
//   Load cnt = LAT-1, where LAT = WRITE_LATENCY if we, else READ_LATENCY. Go to ACCESS; ready=0 from the next cycle.
//  ACCESS: decrement cnt. At cnt==0:
//   - burst read: go to BURST and load cnt=BURST_BEATS-1.
//   - otherwise: go to RESP.
//  BURST: one 64-bit beat per cycle into ddr_read_data[64*b +: 64], b = 0..BURST_BEATS-1 ascending.
//   On the last beat, go to RESP.
//  RESP: ddr_operation_done=1 for exactly this cycle; next state IDLE.
//   - read: ddr_read_data = mem[line] (burst: full assembled line).
//   - write: mem[line] <= (mem[line] & ~mask) | (data & mask) at the edge entering RESP; ddr_read_data unchanged.
//  Done timing relative to the accept edge:
//   - single read: done is visible LAT cycles after the accept edge.
//   - burst read: done is visible READ_LATENCY+BURST_BEATS cycles after the accept edge.
//   - burst_mode on a write is ignored.
//  ddr_ready=0 in ACCESS, BURST and RESP; back to 1 in the cycle after done.
//  Request fields are used only as latched at accept. Input changes mid-operation are ignored.
//  ddr_chip_enable dropping mid-operation does not abort: the operation completes and done still pulses.
//  chip_enable high in the done cycle is not a new request. chip_enable is resampled only in IDLE.
//  Index bits above LINE_OFF+DEPTH_LOG2 are ignored (address wraps modulo depth); bits below LINE_OFF are ignored.
//  Reset asserted mid-operation: return to IDLE and drop the pending write (no memory update). No done pulse is issued.
// CONFIGURATION
//  DDR_RESP_PROTOCOL_CHECK_EN defined: ddr_protocol_error is set, and stays set until reset, if any of these occur:
//   - in ACCESS/BURST: chip_enable drops, or index/write_enable/burst_mode differ from the latched values;
//   - a burst read has LINE_OFF index bits nonzero.
//   Simulation additionally $display's cycle and cause.
//  Not defined: ddr_protocol_error tied 0 and no checker logic. All other behaviour is identical.
// TESTING
//  1 Reset then idle: ready=1, done=0, read_data=0 for 5 cycles.
//  2 Masked write then read:
//    - write idx 0x40, data all 1s, mask 0x..FF (low 8 bits) -> done 2 cycles after accept.
//    - read idx 0x40 -> done 4 cycles after accept, read_data=0x..00FF; ready back 1 the next cycle.
//  3 Burst read of line 0x1000 preloaded with beats 0..7 = 64'h1111..1 to 64'h8888..8:
//    done 12 cycles after accept, read_data beat order matches the preload.
//  4 Wraparound: write idx (1<<18)|0x80 -> read idx 0x80 returns the same line.
//  5 Mid-operation changes:
//    - chip_enable dropped and index changed at cycle 2 of a read: done still at cycle 4 with the original line.
//    - with DDR_RESP_PROTOCOL_CHECK_EN, protocol_error=1.
//  6 Reset asserted during ACCESS of a write: no done pulse, ready=1 next cycle, later read shows the old data.

Source files
------------

// File: rtl/ddr_sim_responder.sv
// ddr_sim_responder
//   Behavioural DDR target for the sim_ram subsystem. Accepts one request at a
//   time, models access latency and PC burst-fill timing, applies bit-masked
//   512-bit line writes, returns 512-bit line reads and pulses
//   ddr_operation_done for one cycle.
//
//   Optional feature macro: DDR_RESP_PROTOCOL_CHECK_EN
//     defined     -> sticky ddr_protocol_error on mid-operation request changes
//                    or on a burst read with nonzero in-line offset bits
//     not defined -> ddr_protocol_error tied low, no checker logic
//
// Ports
//   clock               in   1    system clock, rising edge
//   reset               in   1    synchronous active-high reset
//   ddr_chip_enable     in   1    request valid, held by initiator until done
//   ddr_index           in   64   byte address
//   ddr_write_enable    in   1    1 = write, 0 = read
//   ddr_burst_mode      in   1    1 = burst read (ignored on writes)
//   ddr_write_mask      in   512  per-bit write enable
//   ddr_write_data      in   512  write line
//   ddr_read_data       out  512  read line, valid in done cycle, then held
//   ddr_operation_done  out  1    one-cycle completion pulse
//   ddr_ready           out  1    high only in IDLE
//   ddr_protocol_error  out  1    sticky protocol-violation flag
module ddr_sim_responder #(
    parameter int LINE_OFF      = 6,
    parameter int DEPTH_LOG2    = 12,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2,
    parameter int BURST_BEATS   = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ddr_chip_enable,
    input  logic [63:0]  ddr_index,
    input  logic         ddr_write_enable,
    input  logic         ddr_burst_mode,
    input  logic [511:0] ddr_write_mask,
    input  logic [511:0] ddr_write_data,
    output logic [511:0] ddr_read_data,
    output logic         ddr_operation_done,
    output logic         ddr_ready,
    output logic         ddr_protocol_error
);

    localparam int CNT_W = 16;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_BURST  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [DEPTH_LOG2-1:0]   line_r;
    logic                    we_r;
    logic                    burst_r;
    logic [511:0]            mask_r;
    logic [511:0]            data_r;

    // Storage is deliberately not reset so contents survive a reset.
    logic [511:0]            mem [0:DEPTH-1];

    logic [511:0]            mem_line_s;
    logic [DEPTH_LOG2-1:0]   req_line_s;
    logic                    access_end_s;
    logic                    mem_wr_s;
    logic [CNT_W-1:0]        beat_s;
    logic                    unused_index_s;

    // Decode of the latched line, incoming line, and the end-of-access/write strobes.
    always_comb begin
        mem_line_s     = mem[line_r];
        req_line_s     = ddr_index[LINE_OFF+DEPTH_LOG2-1:LINE_OFF];
        access_end_s   = (state_r == ST_ACCESS) && (cnt_r == {CNT_W{1'b0}});
        // A reset in the same cycle discards the pending write.
        mem_wr_s       = access_end_s && we_r && !reset;
        // Counter runs down during BURST, beats fill upward from 0.
        beat_s         = CNT_W'(BURST_BEATS - 1) - cnt_r;
        unused_index_s = ^{ddr_index[63:LINE_OFF+DEPTH_LOG2], ddr_index[LINE_OFF-1:0]};
    end

    // Masked line write on the edge that enters RESP.
    always_ff @(posedge clock) begin
        if (mem_wr_s) begin
            mem[line_r] <= (mem_line_s & ~mask_r) | (data_r & mask_r);
        end
    end

    // Request FSM with registered ready/done/read-data outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r            <= ST_IDLE;
            cnt_r              <= {CNT_W{1'b0}};
            line_r             <= {DEPTH_LOG2{1'b0}};
            we_r               <= 1'b0;
            burst_r            <= 1'b0;
            mask_r             <= 512'd0;
            data_r             <= 512'd0;
            ddr_read_data      <= 512'd0;
            ddr_operation_done <= 1'b0;
            ddr_ready          <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ddr_operation_done <= 1'b0;
                    if (ddr_chip_enable) begin
                        line_r    <= req_line_s;
                        we_r      <= ddr_write_enable;
                        burst_r   <= ddr_burst_mode & ~ddr_write_enable;
                        mask_r    <= ddr_write_mask;
                        data_r    <= ddr_write_data;
                        cnt_r     <= ddr_write_enable ? CNT_W'(WRITE_LATENCY - 1)
                                                      : CNT_W'(READ_LATENCY - 1);
                        state_r   <= ST_ACCESS;
                        ddr_ready <= 1'b0;
                    end else begin
                        ddr_ready <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (burst_r) begin
                            cnt_r   <= CNT_W'(BURST_BEATS - 1);
                            state_r <= ST_BURST;
                        end else begin
                            state_r            <= ST_RESP;
                            ddr_operation_done <= 1'b1;
                            if (!we_r) begin
                                ddr_read_data <= mem_line_s;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_BURST: begin
                    for (int b = 0; b < BURST_BEATS; b++) begin
                        if (beat_s == CNT_W'(b)) begin
                            ddr_read_data[64*b +: 64] <= mem_line_s[64*b +: 64];
                        end
                    end
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r            <= ST_RESP;
                        ddr_operation_done <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    ddr_operation_done <= 1'b0;
                    ddr_ready          <= 1'b1;
                    state_r            <= ST_IDLE;
                end
                default: begin
                    ddr_operation_done <= 1'b0;
                    ddr_ready          <= 1'b1;
                    state_r            <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DDR_RESP_PROTOCOL_CHECK_EN
    logic [63:0] index_r;
    logic        we_raw_r;
    logic        burst_raw_r;
    logic        err_r;

    // Sticky protocol checker comparing live request fields with the accepted ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            index_r     <= 64'd0;
            we_raw_r    <= 1'b0;
            burst_raw_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && ddr_chip_enable) begin
                index_r     <= ddr_index;
                we_raw_r    <= ddr_write_enable;
                burst_raw_r <= ddr_burst_mode;
                if (!ddr_write_enable && ddr_burst_mode &&
                    (ddr_index[LINE_OFF-1:0] != {LINE_OFF{1'b0}})) begin
                    err_r <= 1'b1;
                end
            end else if ((state_r == ST_ACCESS || state_r == ST_BURST) &&
                         (!ddr_chip_enable || ddr_index != index_r ||
                          ddr_write_enable != we_raw_r || ddr_burst_mode != burst_raw_r)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign ddr_protocol_error = err_r;
`else
    assign ddr_protocol_error = 1'b0;
`endif

endmodule
